uart_result_packetizer: RTL

UART_RESULT_PACKETIZER -- requirements
Module: uart_result_packetizer

---
 rtl/uart_result_packetizer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_result_packetizer.sv
// Frames up to MAX_WORDS 32-bit result words as SOF/LEN/payload bytes for a byte-wide UART.
// Optional feature macro: PKT_CHECKSUM_EN appends an XOR checksum byte (LEN and payload).
module uart_result_packetizer #(
    parameter int MAX_WORDS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [2:0]              word_count_i,
    input  logic [MAX_WORDS*32-1:0] payload_i,
    output logic                    ready_o,
    output logic [7:0]              tx_data_o,
    output logic                    tx_send_o,
    input  logic                    tx_busy_i,
    input  logic                    tx_done_i,
    output logic                    pkt_done_o,
    output logic                    req_error_o,
    output logic [15:0]             frames_sent_o
);
    localparam logic [7:0] SOF    = 8'hAA;
    localparam logic [2:0] MAX_WC = 3'(MAX_WORDS);
    localparam int         NBYTES = MAX_WORDS * 4;

`ifdef PKT_CHECKSUM_EN
    localparam logic [4:0] TAIL = 5'd2;

    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`else
    localparam logic [4:0] TAIL = 5'd1;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        FINISH    = 2'd3
    } state_e;

    state_e                  state_q;
    logic [MAX_WORDS*32-1:0] payload_q;
    logic [2:0]              wcnt_q;
    logic [4:0]              idx_q;
    logic                    ready_q;
    logic                    tx_send_q;
    logic                    pkt_done_q;
    logic                    req_error_q;
    logic [7:0]              tx_data_q;
    logic [15:0]             frames_sent_q;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]              chk_q;
`endif

    logic                    req_ok_s;
    logic [4:0]              last_idx_s;
    logic [4:0]              pl_idx_s;
    logic [7:0]              pl_byte_s;
    logic [7:0]              cur_byte_s;

    assign req_ok_s = (word_count_i != 3'd0) && (word_count_i <= MAX_WC);

    // Selects the byte the frame needs at the current byte index.
    always_comb begin
        last_idx_s = {wcnt_q, 2'b00} + TAIL;
        pl_idx_s   = idx_q - 5'd2;
        pl_byte_s  = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            pl_byte_s = pl_byte_s | ({8{pl_idx_s == 5'(k)}} & payload_q[k*8 +: 8]);
        end
        if (idx_q == 5'd0) begin
            cur_byte_s = SOF;
        end else if (idx_q == 5'd1) begin
            cur_byte_s = {3'b000, wcnt_q, 2'b00};
`ifdef PKT_CHECKSUM_EN
        end else if (idx_q == last_idx_s) begin
            cur_byte_s = chk_q;
`endif
        end else begin
            cur_byte_s = pl_byte_s;
        end
    end

    // Frame sequencer with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            payload_q     <= '0;
            wcnt_q        <= 3'd0;
            idx_q         <= 5'd0;
            ready_q       <= 1'b1;
            tx_send_q     <= 1'b0;
            pkt_done_q    <= 1'b0;
            req_error_q   <= 1'b0;
            tx_data_q     <= 8'h00;
            frames_sent_q <= 16'h0000;
`ifdef PKT_CHECKSUM_EN
            chk_q         <= 8'h00;
`endif
        end else begin
            tx_send_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            req_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (req_ok_s) begin
                            payload_q <= payload_i;
                            wcnt_q    <= word_count_i;
                            idx_q     <= 5'd0;
`ifdef PKT_CHECKSUM_EN
                            chk_q     <= 8'h00;
`endif
                            state_q   <= ISSUE;
                            ready_q   <= 1'b0;
                        end else begin
                            req_error_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!tx_busy_i) begin
                        tx_data_q <= cur_byte_s;
                        tx_send_q <= 1'b1;
`ifdef PKT_CHECKSUM_EN
                        // SOF and the checksum byte itself stay out of the accumulator.
                        if ((idx_q != 5'd0) && (idx_q != last_idx_s)) begin
                            chk_q <= chk_next(chk_q, cur_byte_s);
                        end
`endif
                        state_q   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done_i) begin
                        idx_q <= idx_q + 5'd1;
                        if (idx_q == last_idx_s) begin
                            state_q <= FINISH;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    pkt_done_q    <= 1'b1;
                    frames_sent_q <= frames_sent_q + 16'd1;
                    state_q       <= IDLE;
                    ready_q       <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o       = ready_q;
    assign tx_data_o     = tx_data_q;
    assign tx_send_o     = tx_send_q;
    assign pkt_done_o    = pkt_done_q;
    assign req_error_o   = req_error_q;
    assign frames_sent_o = frames_sent_q;

endmodule
